ex_stage_pipe: RTL and testbench

//  Parametrised execute stage: single-cycle ALU plus serial (1 bit/cycle) unsigned multiplier/divider.

---
 rtl/ex_stage_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_ex_stage_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_pipe.sv
// Execute stage: single-cycle ALU plus a serial (1 bit/cycle) unsigned multiplier/divider,
// feeding a registered EX/WB slot with valid/ready handshakes on both sides.
module ex_stage_pipe #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RADDR_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [3:0]         op_i,
   input  logic [XLEN-1:0]    opa_i,
   input  logic [XLEN-1:0]    opb_i,
   input  logic [RADDR_W-1:0] rd_i,
   input  logic               we_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [XLEN-1:0]    out_wdata_o,
   output logic [RADDR_W-1:0] out_waddr_o,
   output logic               out_we_o,
   output logic               busy_o
);

   localparam int unsigned SHAMT_W = $clog2(XLEN);
   localparam int unsigned CNT_W   = $clog2(XLEN) + 1;

   localparam logic [3:0] OpAdd   = 4'd0;
   localparam logic [3:0] OpSub   = 4'd1;
   localparam logic [3:0] OpAnd   = 4'd2;
   localparam logic [3:0] OpOr    = 4'd3;
   localparam logic [3:0] OpXor   = 4'd4;
   localparam logic [3:0] OpSll   = 4'd5;
   localparam logic [3:0] OpSrl   = 4'd6;
   localparam logic [3:0] OpSra   = 4'd7;
   localparam logic [3:0] OpSlt   = 4'd8;
   localparam logic [3:0] OpSltu  = 4'd9;
   localparam logic [3:0] OpMul   = 4'd10;
   localparam logic [3:0] OpMulhu = 4'd11;
   localparam logic [3:0] OpDivu  = 4'd12;
   localparam logic [3:0] OpRemu  = 4'd13;

   typedef enum logic [1:0] {StIdle, StMdBusy, StMdDone} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [3:0]           md_op_q, md_op_d;
   logic [RADDR_W-1:0]   md_rd_q, md_rd_d;
   logic                 md_we_q, md_we_d;
   logic [XLEN-1:0]      opnd_q, opnd_d;   // multiplicand or divisor
   logic [XLEN-1:0]      acc_q, acc_d;     // product high half / remainder
   logic [XLEN-1:0]      lo_q, lo_d;       // product low half / quotient
   logic                 out_valid_q, out_valid_d;
   logic [XLEN-1:0]      out_wdata_q, out_wdata_d;
   logic [RADDR_W-1:0]   out_waddr_q, out_waddr_d;
   logic                 out_we_q, out_we_d;

   logic [XLEN-1:0]      alu_res;
   logic [SHAMT_W-1:0]   shamt;
   logic                 is_md, is_rsvd, md_is_div, md_hi_sel;
   logic [XLEN:0]        mul_sum, div_shift, div_diff;
   logic                 div_ge;
   logic [XLEN-1:0]      md_acc_nxt, md_lo_nxt, md_res;
   logic                 accept, slot_free;

   assign shamt     = opb_i[SHAMT_W-1:0];
   assign is_md     = (op_i >= OpMul) && (op_i <= OpRemu);
   assign is_rsvd   = (op_i[3:1] == 3'b111);
   assign md_is_div = (md_op_q == OpDivu) || (md_op_q == OpRemu);
   assign md_hi_sel = (md_op_q == OpMulhu) || (md_op_q == OpRemu);
   assign slot_free = !out_valid_q || out_ready_i;

   assign in_ready_o  = (state_q == StIdle) && slot_free && !flush_i && !rst_i;
   assign accept      = in_valid_i && in_ready_o;
   assign busy_o      = (state_q != StIdle);
   assign out_valid_o = out_valid_q;
   assign out_wdata_o = out_wdata_q;
   assign out_waddr_o = out_waddr_q;
   assign out_we_o    = out_we_q;

   // Single-cycle ALU; reserved opcodes fall through to zero
   always_comb begin
      alu_res = '0;
      case (op_i)
         OpAdd:   alu_res = opa_i + opb_i;
         OpSub:   alu_res = opa_i - opb_i;
         OpAnd:   alu_res = opa_i & opb_i;
         OpOr:    alu_res = opa_i | opb_i;
         OpXor:   alu_res = opa_i ^ opb_i;
         OpSll:   alu_res = opa_i << shamt;
         OpSrl:   alu_res = opa_i >> shamt;
         OpSra:   alu_res = $unsigned($signed(opa_i) >>> shamt);
         OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(opa_i) < $signed(opb_i)};
         OpSltu:  alu_res = {{(XLEN-1){1'b0}}, opa_i < opb_i};
         default: alu_res = '0;
      endcase
   end

   // One shift-add or restoring-divide iteration; a zero divisor always "subtracts",
   // which naturally yields an all-ones quotient and remainder equal to the dividend
   always_comb begin
      mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {acc_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      if (md_is_div) begin
         md_acc_nxt = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
         md_lo_nxt  = {lo_q[XLEN-2:0], div_ge};
      end else begin
         md_acc_nxt = mul_sum[XLEN:1];
         md_lo_nxt  = {mul_sum[0], lo_q[XLEN-1:1]};
      end
      md_res = md_hi_sel ? acc_q : lo_q;
   end

   // Next-state: FSM, multdiv datapath and output slot; flush overrides everything
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      md_op_d     = md_op_q;
      md_rd_d     = md_rd_q;
      md_we_d     = md_we_q;
      opnd_d      = opnd_q;
      acc_d       = acc_q;
      lo_d        = lo_q;
      out_valid_d = out_valid_q;
      out_wdata_d = out_wdata_q;
      out_waddr_d = out_waddr_q;
      out_we_d    = out_we_q;

      if (out_valid_q && out_ready_i) out_valid_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept) begin
               if (is_md) begin
                  state_d = StMdBusy;
                  cnt_d   = CNT_W'(XLEN);
                  md_op_d = op_i;
                  md_rd_d = rd_i;
                  md_we_d = we_i;
                  acc_d   = '0;
                  if ((op_i == OpDivu) || (op_i == OpRemu)) begin
                     opnd_d = opb_i;
                     lo_d   = opa_i;
                  end else begin
                     opnd_d = opa_i;
                     lo_d   = opb_i;
                  end
               end else begin
                  out_valid_d = 1'b1;
                  out_wdata_d = alu_res;
                  out_waddr_d = rd_i;
                  out_we_d    = we_i && !is_rsvd;
               end
            end
         end
         StMdBusy: begin
            acc_d = md_acc_nxt;
            lo_d  = md_lo_nxt;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = StMdDone;
         end
         StMdDone: begin
            if (slot_free) begin
               out_valid_d = 1'b1;
               out_wdata_d = md_res;
               out_waddr_d = md_rd_q;
               out_we_d    = md_we_q;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (flush_i) begin
         state_d     = StIdle;
         out_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset clearing the whole datapath
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         md_op_q     <= '0;
         md_rd_q     <= '0;
         md_we_q     <= 1'b0;
         opnd_q      <= '0;
         acc_q       <= '0;
         lo_q        <= '0;
         out_valid_q <= 1'b0;
         out_wdata_q <= '0;
         out_waddr_q <= '0;
         out_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         md_op_q     <= md_op_d;
         md_rd_q     <= md_rd_d;
         md_we_q     <= md_we_d;
         opnd_q      <= opnd_d;
         acc_q       <= acc_d;
         lo_q        <= lo_d;
         out_valid_q <= out_valid_d;
         out_wdata_q <= out_wdata_d;
         out_waddr_q <= out_waddr_d;
         out_we_q    <= out_we_d;
      end
   end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed testbench for ex_stage_pipe at default parameters (XLEN=32, RADDR_W=5).
module tb_ex_stage_pipe;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready, we, out_we, busy;
   logic [3:0]  op;
   logic [31:0] opa, opb, out_wdata;
   logic [4:0]  rd, out_waddr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_stage_pipe dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .op_i        (op),
      .opa_i       (opa),
      .opb_i       (opb),
      .rd_i        (rd),
      .we_i        (we),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_wdata_o (out_wdata),
      .out_waddr_o (out_waddr),
      .out_we_o    (out_we),
      .busy_o      (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
      in_valid = 1'b1;
      op       = o;
      opa      = a;
      opb      = b;
      rd       = r;
      we       = 1'b1;
   endtask

   // Single-cycle op with out_ready high: result in the slot one edge after accept
   task automatic sc(input string tag, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
      drive(o, a, b, 5'd9);
      #1 chk({tag, " in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk({tag, " valid"}, out_valid, 1);
      chk({tag, " wdata"}, out_wdata, exp);
   endtask

   // Multicycle op: count edges from accept to out_valid, expect 33
   task automatic md(input string tag, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
      int n;
      drive(o, a, b, 5'd17);
      #1 chk({tag, " in_ready"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk({tag, " busy"}, busy, 1);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk({tag, " latency"}, n, 33);
      chk({tag, " wdata"}, out_wdata, exp);
      chk({tag, " waddr"}, out_waddr, 17);
      chk({tag, " busy_done"}, busy, 0);
      tick();
      chk({tag, " drained"}, out_valid, 0);
   endtask

   // Start DIVU, kill it at cycle 10 with flush or reset, then ensure nothing emerges
   task automatic kill_md(input string tag, input bit use_rst);
      int seen;
      drive(4'd12, 32'd1000, 32'd3, 5'd11);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk({tag, " busy_before"}, busy, 1);
      if (use_rst) rst = 1'b1;
      else flush = 1'b1;
      #1 chk({tag, " in_ready_kill"}, in_ready, 0);
      tick();
      rst   = 1'b0;
      flush = 1'b0;
      chk({tag, " busy_after"}, busy, 0);
      chk({tag, " valid_after"}, out_valid, 0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid) seen++;
      end
      chk({tag, " no_result"}, seen, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; opa = '0; opb = '0; rd = '0; we = 1'b0;
      tick();
      tick();
      chk("rst valid", out_valid, 0);
      chk("rst wdata", out_wdata, 0);
      chk("rst waddr", out_waddr, 0);
      chk("rst we", out_we, 0);
      chk("rst busy", busy, 0);
      chk("rst in_ready", in_ready, 0);
      rst = 1'b0;
      #1 chk("post-rst in_ready", in_ready, 1);
      tick();

      // Back-to-back ADD then SRA, sustained 1 op/cycle
      drive(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd3);
      #1 chk("t1 ready0", in_ready, 1);
      tick();
      chk("t1 add valid", out_valid, 1);
      chk("t1 add wdata", out_wdata, 32'h0);
      chk("t1 add waddr", out_waddr, 3);
      chk("t1 add we", out_we, 1);
      drive(4'd7, 32'h8000_0000, 32'd31, 5'd4);
      #1 chk("t1 ready1", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("t1 sra valid", out_valid, 1);
      chk("t1 sra wdata", out_wdata, 32'hFFFF_FFFF);
      chk("t1 sra waddr", out_waddr, 4);
      tick();
      chk("t1 drained", out_valid, 0);

      // Misc single-cycle ops
      sc("sub", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
      sc("sll", 4'd5, 32'd1, 32'd33, 32'd2);
      sc("srl", 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000);
      sc("slt", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1);
      sc("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0);
      sc("or", 4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
      tick();

      // Multiply and divide
      md("mul", 4'd10, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
      md("mulhu", 4'd11, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002);
      md("divu", 4'd12, 32'd100, 32'd7, 32'd14);
      md("remu", 4'd13, 32'd100, 32'd7, 32'd2);
      md("divu0", 4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF);
      md("remu0", 4'd13, 32'd5, 32'd0, 32'd5);

      // Backpressure: slot stable 5 cycles, next op accepted on release
      out_ready = 1'b0;
      drive(4'd0, 32'd2, 32'd3, 5'd7);
      tick();
      drive(4'd4, 32'hF0, 32'hFF, 5'd8);
      for (int i = 0; i < 5; i++) begin
         chk("t4 in_ready", in_ready, 0);
         chk("t4 valid", out_valid, 1);
         chk("t4 wdata", out_wdata, 5);
         chk("t4 waddr", out_waddr, 7);
         tick();
      end
      out_ready = 1'b1;
      #1 chk("t4 release ready", in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk("t4 next valid", out_valid, 1);
      chk("t4 next wdata", out_wdata, 32'h0F);
      chk("t4 next waddr", out_waddr, 8);
      tick();

      // Abandon multdiv via flush, then via reset
      kill_md("flush", 1'b0);
      kill_md("reset", 1'b1);
      chk("reset wdata cleared", out_wdata, 0);

      // Reserved op: completes, no write
      drive(4'd15, 32'd5, 32'd6, 5'd21);
      tick();
      in_valid = 1'b0;
      chk("rsvd valid", out_valid, 1);
      chk("rsvd we", out_we, 0);
      chk("rsvd wdata", out_wdata, 0);
      chk("rsvd waddr", out_waddr, 21);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
